median_frame_sequencer: RTL and testbench

- Frame-level controller that drives the 3x3 median filter datapath over a full ROW x COL 8-bit image.
- Scans pixels column-major: pixel index = c*ROW + r, with r running fastest.
- For each pixel, it:
  - fetches the 3x3 neighbourhood from a synchronous-read source image RAM,
  - presents the window and pixel index to the filter,
  - waits for the filter's registered result,
  - writes that result to a destination RAM.
- Sits between the frame buffers and the filter; it is the only master of both RAM ports.

---
 rtl/median_pkg.sv | 31 +++
 rtl/median_tap_addr_gen.sv | 61 ++++++
 rtl/median_frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared definitions for the median frame sequencer:
//   - state_t  : sequencer FSM states
//   - WIN_TAPS : taps in the 3x3 window
//   - PIX_W    : pixel width in bits
//   - clamp()  : saturate an integer into [lo, hi]
// ---------------------------------------------------------------------------
package median_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    FILT,
    WRITE
  } state_t;

  localparam int WIN_TAPS = 9;
  localparam int PIX_W    = 8;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/median_tap_addr_gen.sv
// ---------------------------------------------------------------------------
// median_tap_addr_gen
// Combinational mapping of the current pixel position and tap number to the
// clamped source address of that tap.
//   tap k = 3*dr + dc, r' = clamp(r+dr-1), c' = clamp(c+dc-1),
//   addr  = c'*ROW + r'
// The column products c'*ROW are never computed here; the caller supplies
// the left/centre/right column base addresses as running registers.
// Ports:
//   r, c     in  current row / column
//   base_l   in  (c-1)*ROW (meaningless when c == 0)
//   base_c   in  c*ROW
//   base_r   in  (c+1)*ROW (meaningless when c == COL-1)
//   k        in  tap number 0..8
//   addr     out clamped source address of tap k
// ---------------------------------------------------------------------------
module median_tap_addr_gen
  import median_pkg::*;
#(
  parameter int ROW    = 430,
  parameter int COL    = 554,
  parameter int ADDR_W = 18
) (
  input  logic [ADDR_W-1:0] r,
  input  logic [ADDR_W-1:0] c,
  input  logic [ADDR_W-1:0] base_l,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] base_r,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] COL_M1 = ADDR_W'(COL - 1);

  int                dr;
  int                dc;
  int                rv;
  logic [ADDR_W-1:0] col_base;

  always_comb begin
    dr       = 0;
    dc       = 0;
    rv       = 0;
    col_base = base_c;
    // Split k into row/column offsets without a divider.
    if (k >= 4'd6)
      dr = 2;
    else if (k >= 4'd3)
      dr = 1;
    dc = int'(k) - 3 * dr;
    rv = clamp(int'(r) + dr - 1, 0, ROW - 1);
    // Column clamp: at the frame edges the neighbour column collapses onto c.
    case (dc)
      0:       col_base = (c == '0)     ? base_c : base_l;
      2:       col_base = (c == COL_M1) ? base_c : base_r;
      default: col_base = base_c;
    endcase
    addr = col_base + rv[ADDR_W-1:0];
  end

endmodule

// File: rtl/median_frame_sequencer.sv
// ---------------------------------------------------------------------------
// median_frame_sequencer
// Drives a 3x3 median filter over a ROW x COL 8-bit image, column-major
// (pixel index = c*ROW + r, r fastest). Per pixel: fetch the 3x3 window from
// the synchronous-read source RAM, present it to the filter, then write the
// filter's registered result to the destination RAM.
//
// Optional build macro: MEDIAN_WINDOW_REUSE_EN
//   When defined, pixels with r > 0 reuse rows r-1 and r of the previous
//   window and only fetch the three taps of row r+1 (6 cycles per pixel).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   frame request, only honoured in IDLE
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last pixel write
//   rd_en      out  source RAM read strobe
//   rd_addr    out  source RAM address
//   rd_data    in   source RAM data, one cycle after rd_en
//   pixel_idx  out  pixel index presented to the filter (zero-extended)
//   win_data   out  3x3 window, byte k = tap k = 3*dr + dc
//   filt_data  in   filter result (registered by the filter)
//   wr_en      out  destination RAM write strobe
//   wr_addr    out  destination address (= pixel index)
//   wr_data    out  destination data
// ---------------------------------------------------------------------------
module median_frame_sequencer
  import median_pkg::*;
#(
  parameter int ROW    = 430,
  parameter int COL    = 554,
  parameter int ADDR_W = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [PIX_W-1:0]          rd_data,
  output logic [31:0]               pixel_idx,
  output logic [WIN_TAPS*PIX_W-1:0] win_data,
  input  logic [PIX_W-1:0]          filt_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [PIX_W-1:0]          wr_data
);

  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ROW);
  localparam logic [ADDR_W-1:0] ROW_M1 = ADDR_W'(ROW - 1);
  localparam logic [ADDR_W-1:0] COL_M1 = ADDR_W'(COL - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        k;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] c;
  logic [ADDR_W-1:0] pix;
  logic [ADDR_W-1:0] base_l;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] tap_addr;
  logic              last_pix;
  logic              vld_p1;
  logic [3:0]        tap_p1;
  logic [PIX_W-1:0]  win [WIN_TAPS];

  median_tap_addr_gen #(
    .ROW    (ROW),
    .COL    (COL),
    .ADDR_W (ADDR_W)
  ) u_tap_addr (
    .r      (r),
    .c      (c),
    .base_l (base_l),
    .base_c (base_c),
    .base_r (base_r),
    .k      (k),
    .addr   (tap_addr)
  );

  assign last_pix  = (r == ROW_M1) && (c == COL_M1);
  assign pixel_idx = {{(32 - ADDR_W){1'b0}}, pix};

  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN_TAPS; i++)
      win_data[i*PIX_W +: PIX_W] = win[i];
  end

  // Next state and strobes; outputs are zero outside their own state so a
  // reset silences both RAM ports at once.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = tap_addr;
        if (k == 4'd8)
          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = FILT;
      FILT:  state_nxt = WRITE;
      WRITE: begin
        wr_en     = 1'b1;
        wr_addr   = pix;
        wr_data   = filt_data;
        state_nxt = last_pix ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      k      <= '0;
      r      <= '0;
      c      <= '0;
      pix    <= '0;
      base_l <= '0;
      base_c <= '0;
      base_r <= '0;
      vld_p1 <= 1'b0;
      tap_p1 <= '0;
      for (int i = 0; i < WIN_TAPS; i++)
        win[i] <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == WRITE) && last_pix;

      // Read return stage: the tap issued last cycle lands in its byte now.
      vld_p1 <= rd_en;
      tap_p1 <= k;
      if (vld_p1)
        win[tap_p1] <= rd_data;

      case (state)
        IDLE: begin
          if (start) begin
            k      <= '0;
            r      <= '0;
            c      <= '0;
            pix    <= '0;
            base_c <= '0;
            base_l <= '0 - ROW_A;
            base_r <= ROW_A;
          end
        end
        FETCH: k <= k + 4'd1;
        WRITE: begin
          if (!last_pix) begin
            pix <= pix + 1'b1;
            if (r == ROW_M1) begin
              r      <= '0;
              c      <= c + 1'b1;
              base_l <= base_l + ROW_A;
              base_c <= base_c + ROW_A;
              base_r <= base_r + ROW_A;
              k      <= '0;
            end else begin
              r <= r + 1'b1;
`ifdef MEDIAN_WINDOW_REUSE_EN
              // Rows r and r+1 of this window become rows r-1 and r of the
              // next one; only the new bottom row is fetched.
              for (int i = 0; i < 6; i++)
                win[i] <= win[i+3];
              k <= 4'd6;
`else
              k <= '0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_sequencer.sv
module tb_median_frame_sequencer;

  localparam int ROW    = 4;
  localparam int COL    = 3;
  localparam int ADDR_W = 4;
  localparam int NPIX   = ROW * COL;
`ifdef MEDIAN_WINDOW_REUSE_EN
  localparam bit REUSE     = 1'b1;
  localparam int FRAME_CYC = COL * (12 + 6 * (ROW - 1));
`else
  localparam bit REUSE     = 1'b0;
  localparam int FRAME_CYC = 12 * NPIX;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [31:0]       pixel_idx;
  logic [71:0]       win_data;
  logic [7:0]        filt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic [7:0] src [NPIX];
  int         wr_log_addr[$];
  int         wr_log_data[$];
  int         rd_log[$];
  int         done_cnt;
  int         busy_gap;
  bit         in_frame;
  int         n_vec;
  int         n_err;

  always #5 clk = ~clk;

  median_frame_sequencer #(
    .ROW    (ROW),
    .COL    (COL),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pixel_idx (pixel_idx),
    .win_data  (win_data),
    .filt_data (filt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  function automatic int med9(input int v [9]);
    int a [9];
    int t;
    a = v;
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    return a[4];
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Expected output pixel: median of the edge-replicated 3x3 neighbourhood.
  function automatic int exp_pix(input int r, input int c);
    int v [9];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[3*dr+dc] = int'(src[clampi(c+dc-1, 0, COL-1)*ROW + clampi(r+dr-1, 0, ROW-1)]);
    return med9(v);
  endfunction

  // Source RAM: synchronous read, data one cycle after the strobe.
  always @(posedge clk)
    if (rd_en)
      rd_data <= (int'(rd_addr) < NPIX) ? src[int'(rd_addr)] : 8'h00;

  // Filter stand-in: registered median of whatever window is presented.
  always @(posedge clk) begin
    int w [9];
    for (int i = 0; i < 9; i++)
      w[i] = int'(win_data[i*8 +: 8]);
    filt_data <= 8'(med9(w));
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wr_log_addr.push_back(int'(wr_addr));
      wr_log_data.push_back(int'(wr_data));
    end
    if (rd_en)
      rd_log.push_back(int'(rd_addr));
    if (done)
      done_cnt++;
    if (in_frame && !busy)
      busy_gap++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log_addr.delete();
    wr_log_data.delete();
    rd_log.delete();
    done_cnt = 0;
    busy_gap = 0;
  endtask

  task automatic run_frame(input string name, input bit extra_start);
    int cyc;
    int exp_rd[$];
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    in_frame = 1'b1;
    cyc = 0;
    while (!done && cyc < FRAME_CYC + 50) begin
      @(posedge clk);
      cyc++;
      #1;
      start = extra_start && (cyc == 40);
    end
    start    = 1'b0;
    in_frame = 1'b0;
    check_val({name, "_done_latency"}, cyc, FRAME_CYC);
    check_val({name, "_busy_at_done"}, busy, 0);
    repeat (2) @(negedge clk);
    check_val({name, "_done_pulses"}, done_cnt, 1);
    check_val({name, "_busy_gap"}, busy_gap, 0);

    check_val({name, "_wr_count"}, wr_log_addr.size(), NPIX);
    for (int i = 0; i < NPIX && i < wr_log_addr.size(); i++) begin
      check_val($sformatf("%s_wr_addr%0d", name, i), wr_log_addr[i], i);
      check_val($sformatf("%s_wr_data%0d", name, i), wr_log_data[i], exp_pix(i % ROW, i / ROW));
    end

    for (int p = 0; p < NPIX; p++) begin
      int r = p % ROW;
      int c = p / ROW;
      for (int k = (REUSE && r > 0) ? 6 : 0; k < 9; k++)
        exp_rd.push_back(clampi(c + k % 3 - 1, 0, COL-1) * ROW + clampi(r + k / 3 - 1, 0, ROW-1));
    end
    check_val({name, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check_val($sformatf("%s_rd_addr%0d", name, i), rd_log[i], exp_rd[i]);
  endtask

  task automatic reset_mid_frame();
    int cyc;
    int rd_n;
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (wr_log_addr.size() < 7 && cyc < FRAME_CYC) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check_val("rst_reach_px7", wr_log_addr.size(), 7);
    @(negedge clk) rst = 1'b1;
    #1;
    check_val("rst_async_rd_en", rd_en, 0);
    check_val("rst_async_wr_en", wr_en, 0);
    check_val("rst_async_busy", busy, 0);
    check_val("rst_async_pixel_idx", pixel_idx, 0);
    check_val("rst_async_win_nz", {31'b0, |win_data}, 0);
    rd_n = rd_log.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_val("rst_no_more_writes", wr_log_addr.size(), 7);
    check_val("rst_no_more_reads", rd_log.size(), rd_n);
    check_val("rst_no_done", done_cnt, 0);
    check_val("rst_idle_busy", busy, 0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_frame = 1'b0;
    rd_data  = '0;
    for (int i = 0; i < NPIX; i++)
      src[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_rd_en", rd_en, 0);
    check_val("reset_wr_en", wr_en, 0);
    check_val("reset_rd_addr", rd_addr, 0);
    check_val("reset_wr_addr", wr_addr, 0);
    check_val("reset_wr_data", wr_data, 0);
    check_val("reset_pixel_idx", pixel_idx, 0);
    check_val("reset_win_nz", {31'b0, |win_data}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NPIX; i++)
      src[i] = 8'h55;
    run_frame("const55", 1'b0);

    for (int i = 0; i < NPIX; i++)
      src[i] = 8'h10;
    src[5] = 8'hFF;
    run_frame("impulse", 1'b0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NPIX; i++)
        src[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", t), 1'b0);
    end

    for (int i = 0; i < NPIX; i++)
      src[i] = 8'($urandom);
    run_frame("restart_ignored", 1'b1);

    reset_mid_frame();
    for (int i = 0; i < NPIX; i++)
      src[i] = 8'($urandom_range(0, 255));
    run_frame("after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
